reorder_buffer: RTL and testbench

- Circular in-order reorder buffer for the OOPs out-of-order core; single lane (ISSUE_WIDTH=1).
- Allocates one entry per dispatched instruction and drives the register-file speculate port (rd tag = ROB index).
- Captures results from the CDB and retires completed head entries in program order via the register-file commit port.
- Also provides an operand-lookup port so dispatch can read completed-but-uncommitted values.

---
 rtl/reorder_buffer.sv | 106 ++++++++++
 tb/tb_reorder_buffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures CDB results,
// retires completed head entries in program order, and serves operand lookups.
module reorder_buffer #(
    parameter int ROB_IDX_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fls,
    input  logic                   alloc_valid_i,
    input  logic [4:0]             alloc_rd_i,
    output logic                   alloc_ready_o,
    output logic [ROB_IDX_LEN-1:0] alloc_rob_idx_o,
    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_rob_idx_i,
    input  logic [31:0]            cdb_data_i,
    output logic                   commit_o,
    output logic [4:0]             commit_idx_o,
    output logic [ROB_IDX_LEN-1:0] commit_rob_idx_o,
    output logic [31:0]            commit_data_o,
    output logic                   speculate_o,
    output logic [4:0]             speculate_idx_o,
    output logic [ROB_IDX_LEN-1:0] speculate_data_o,
    input  logic [ROB_IDX_LEN-1:0] rd_rob_idx_i,
    output logic                   rd_ready_o,
    output logic [31:0]            rd_data_o,
    output logic                   empty_o,
    output logic [ROB_IDX_LEN:0]   count_o
);

    localparam int DEPTH = 1 << ROB_IDX_LEN;
    localparam logic [ROB_IDX_LEN:0] FULL_COUNT = {1'b1, {ROB_IDX_LEN{1'b0}}};

    logic                   valid [DEPTH];
    logic                   done  [DEPTH];
    logic [4:0]             rd    [DEPTH];
    logic [31:0]            data  [DEPTH];
    logic [ROB_IDX_LEN-1:0] head;
    logic [ROB_IDX_LEN-1:0] tail;
    logic [ROB_IDX_LEN:0]   count;
    logic                   grant;
    logic                   commit;

    // Full is judged on count alone; a retiring head does not free a slot until the next cycle.
    assign alloc_ready_o   = !rst && !fls && (count != FULL_COUNT);
    assign grant           = alloc_valid_i && alloc_ready_o;
    assign alloc_rob_idx_o = tail;

    assign speculate_o      = grant;
    assign speculate_idx_o  = alloc_rd_i;
    assign speculate_data_o = tail;

    assign commit           = !rst && valid[head] && done[head];
    assign commit_o         = commit;
    assign commit_idx_o     = rd[head];
    assign commit_rob_idx_o = head;
    assign commit_data_o    = data[head];

    assign empty_o = (count == '0);
    assign count_o = count;

    always_comb begin
        rd_ready_o = 1'b0;
        rd_data_o  = data[rd_rob_idx_i];
        if (cdb_valid_i && (cdb_rob_idx_i == rd_rob_idx_i) && valid[rd_rob_idx_i]) begin
            rd_ready_o = 1'b1;
            rd_data_o  = cdb_data_i;
        end else if (valid[rd_rob_idx_i] && done[rd_rob_idx_i]) begin
            rd_ready_o = 1'b1;
        end
    end

    // Flush keeps nothing, so the head retirement that cycle needs no state update here.
    always_ff @(posedge clk) begin
        if (rst || fls) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i] <= 1'b0;
                done[i]  <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb_valid_i && valid[cdb_rob_idx_i]) begin
                done[cdb_rob_idx_i] <= 1'b1;
                data[cdb_rob_idx_i] <= cdb_data_i;
            end
            if (commit) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
                head        <= head + 1'b1;
            end
            if (grant) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                rd[tail]    <= alloc_rd_i;
                tail        <= tail + 1'b1;
            end
            case ({grant, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized
// traffic compared against a queue-based program-order model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fls = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic [4:0]  alloc_rd_i = '0;
    logic        alloc_ready_o;
    logic [3:0]  alloc_rob_idx_o;
    logic        cdb_valid_i = 1'b0;
    logic [3:0]  cdb_rob_idx_i = '0;
    logic [31:0] cdb_data_i = '0;
    logic        commit_o;
    logic [4:0]  commit_idx_o;
    logic [3:0]  commit_rob_idx_o;
    logic [31:0] commit_data_o;
    logic        speculate_o;
    logic [4:0]  speculate_idx_o;
    logic [3:0]  speculate_data_o;
    logic [3:0]  rd_rob_idx_i = '0;
    logic        rd_ready_o;
    logic [31:0] rd_data_o;
    logic        empty_o;
    logic [4:0]  count_o;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_IDX_LEN(4)) dut (
        .clk(clk), .rst(rst), .fls(fls),
        .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i),
        .alloc_ready_o(alloc_ready_o), .alloc_rob_idx_o(alloc_rob_idx_o),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_idx_i(cdb_rob_idx_i), .cdb_data_i(cdb_data_i),
        .commit_o(commit_o), .commit_idx_o(commit_idx_o),
        .commit_rob_idx_o(commit_rob_idx_o), .commit_data_o(commit_data_o),
        .speculate_o(speculate_o), .speculate_idx_o(speculate_idx_o),
        .speculate_data_o(speculate_data_o),
        .rd_rob_idx_i(rd_rob_idx_i), .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o),
        .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Program-order model: queue front is the oldest in-flight instruction.
    typedef struct {
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
        int          tag;
    } ent_t;

    ent_t mq[$];
    int   m_tail = 0;

    bit          exp_ready, exp_commit, exp_grant, exp_lk_ready;
    logic [4:0]  exp_commit_rd;
    logic [31:0] exp_commit_data, exp_lk_data;
    int          exp_head;

    function automatic void model_expect();
        exp_ready  = !rst && !fls && (mq.size() < 16);
        exp_grant  = alloc_valid_i && exp_ready;
        exp_commit = !rst && (mq.size() > 0) && mq[0].done;
        exp_head   = (m_tail - mq.size() + 16) % 16;
        exp_commit_rd   = '0;
        exp_commit_data = '0;
        if (mq.size() > 0) begin
            exp_commit_rd   = mq[0].rd;
            exp_commit_data = mq[0].data;
        end
        exp_lk_ready = 1'b0;
        exp_lk_data  = '0;
        foreach (mq[i]) begin
            if (mq[i].tag == int'(rd_rob_idx_i)) begin
                if (cdb_valid_i && cdb_rob_idx_i == rd_rob_idx_i) begin
                    exp_lk_ready = 1'b1;
                    exp_lk_data  = cdb_data_i;
                end else if (mq[i].done) begin
                    exp_lk_ready = 1'b1;
                    exp_lk_data  = mq[i].data;
                end
            end
        end
    endfunction

    function automatic void model_update();
        ent_t e;
        model_expect();
        if (rst || fls) begin
            mq.delete();
            m_tail = 0;
        end else begin
            if (cdb_valid_i) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(cdb_rob_idx_i)) begin
                        mq[i].done = 1'b1;
                        mq[i].data = cdb_data_i;
                    end
                end
            end
            if (exp_commit) void'(mq.pop_front());
            if (exp_grant) begin
                e.rd = alloc_rd_i; e.done = 1'b0; e.data = '0; e.tag = m_tail;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 16;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic cv,
                         input logic [3:0] ci, input logic [31:0] cd,
                         input logic f, input logic [3:0] lk);
        alloc_valid_i = av; alloc_rd_i = ard;
        cdb_valid_i = cv; cdb_rob_idx_i = ci; cdb_data_i = cd;
        fls = f; rd_rob_idx_i = lk;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        drive(1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (alloc_ready_o !== 1'b0 || commit_o !== 1'b0 || speculate_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: ready=%b commit=%b spec=%b required 0/0/0",
                     alloc_ready_o, commit_o, speculate_o);
        end
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0 || alloc_ready_o !== 1'b1 ||
            alloc_rob_idx_o !== 4'd0 || commit_o !== 1'b0 || speculate_o !== 1'b0 ||
            rd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: empty=%b count=%0d ready=%b idx=%0d commit=%b spec=%b rdy=%b required 1/0/1/0/0/0/0",
                     empty_o, count_o, alloc_ready_o, alloc_rob_idx_o, commit_o, speculate_o, rd_ready_o);
        end
    endtask

    task automatic test_single();
        pulse_reset();
        drive(1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (alloc_rob_idx_o !== 4'd0 || speculate_o !== 1'b1 || speculate_idx_o !== 5'd5 ||
            speculate_data_o !== 4'd0) begin
            errors++;
            $display("[TB] FAIL single_alloc: idx=%0d spec=%b rd=%0d tag=%0d required 0/1/5/0",
                     alloc_rob_idx_o, speculate_o, speculate_idx_o, speculate_data_o);
        end
        tick();
        drive(1'b0, 5'd0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0);
        checks++;
        if (commit_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early_commit: commit=%b required 0", commit_o);
        end
        tick();
        idle();
        checks++;
        if (commit_o !== 1'b1 || commit_idx_o !== 5'd5 || commit_rob_idx_o !== 4'd0 ||
            commit_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL single_commit: commit=%b rd=%0d rob=%0d data=%h required 1/5/0/deadbeef",
                     commit_o, commit_idx_o, commit_rob_idx_o, commit_data_o);
        end
        tick();
        checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0) begin
            errors++;
            $display("[TB] FAIL single_empty: empty=%b count=%0d required 1/0", empty_o, count_o);
        end
    endtask

    task automatic test_in_order();
        logic [3:0] order [3];
        order[0] = 4'd2; order[1] = 4'd1; order[2] = 4'd0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            checks++;
            if (alloc_rob_idx_o !== 4'(i)) begin
                errors++;
                $display("[TB] FAIL inorder_alloc: idx=%0d required %0d", alloc_rob_idx_o, i);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b1, order[i], 32'h100 + 32'(order[i]), 1'b0, 4'd0);
            checks++;
            if (commit_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL inorder_wait: commit=%b required 0 step %0d", commit_o, i);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (commit_o !== 1'b1 || commit_idx_o !== 5'(i + 1) || commit_rob_idx_o !== 4'(i) ||
                commit_data_o !== 32'h100 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL inorder_commit: commit=%b rd=%0d rob=%0d data=%h required 1/%0d/%0d/%h",
                         commit_o, commit_idx_o, commit_rob_idx_o, commit_data_o, i + 1, i, 32'h100 + i);
            end
            tick();
        end
    endtask

    task automatic test_full_wrap();
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'(i), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            tick();
        end
        drive(1'b1, 5'd17, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (count_o !== 5'd16 || alloc_ready_o !== 1'b0 || speculate_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_refuse: count=%0d ready=%b spec=%b required 16/0/0",
                     count_o, alloc_ready_o, speculate_o);
        end
        tick();
        drive(1'b1, 5'd18, 1'b1, 4'd0, 32'h55AA, 1'b0, 4'd0);
        tick();
        drive(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (commit_o !== 1'b1 || commit_data_o !== 32'h55AA || alloc_ready_o !== 1'b0 ||
            speculate_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_commit_no_bypass: commit=%b data=%h ready=%b spec=%b required 1/55aa/0/0",
                     commit_o, commit_data_o, alloc_ready_o, speculate_o);
        end
        tick();
        drive(1'b1, 5'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checks++;
        if (alloc_ready_o !== 1'b1 || alloc_rob_idx_o !== 4'd0 || speculate_data_o !== 4'd0 ||
            count_o !== 5'd15) begin
            errors++;
            $display("[TB] FAIL wrap_grant: ready=%b idx=%0d tag=%0d count=%0d required 1/0/0/15",
                     alloc_ready_o, alloc_rob_idx_o, speculate_data_o, count_o);
        end
        tick();
        idle();
        checks++;
        if (count_o !== 5'd16 || alloc_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_full_again: count=%0d ready=%b required 16/0", count_o, alloc_ready_o);
        end
    endtask

    task automatic test_flush();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            tick();
        end
        drive(1'b0, 5'd0, 1'b1, 4'd0, 32'h77, 1'b0, 4'd0);
        tick();
        drive(1'b1, 5'd6, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
        checks++;
        if (commit_o !== 1'b1 || commit_idx_o !== 5'd1 || alloc_ready_o !== 1'b0 || speculate_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_commit: commit=%b rd=%0d ready=%b spec=%b required 1/1/0/0",
                     commit_o, commit_idx_o, alloc_ready_o, speculate_o);
        end
        tick();
        drive(1'b0, 5'd0, 1'b1, 4'd2, 32'h99, 1'b0, 4'd2);
        checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || alloc_rob_idx_o !== 4'd0 || commit_o !== 1'b0 ||
            rd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_state: count=%0d empty=%b idx=%0d commit=%b rdy=%b required 0/1/0/0/0",
                     count_o, empty_o, alloc_rob_idx_o, commit_o, rd_ready_o);
        end
        tick();
        idle();
        checks++;
        if (commit_o !== 1'b0 || count_o !== 5'd0) begin
            errors++;
            $display("[TB] FAIL flush_stale_cdb: commit=%b count=%0d required 0/0", commit_o, count_o);
        end
    endtask

    task automatic test_lookup();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i + 10), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3);
        checks++;
        if (rd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lookup_not_done: rdy=%b required 0", rd_ready_o);
        end
        drive(1'b0, 5'd0, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd3);
        checks++;
        if (rd_ready_o !== 1'b1 || rd_data_o !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL lookup_bypass: rdy=%b data=%h required 1/1234", rd_ready_o, rd_data_o);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3);
        checks++;
        if (rd_ready_o !== 1'b1 || rd_data_o !== 32'h1234 || commit_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lookup_stored: rdy=%b data=%h commit=%b required 1/1234/0",
                     rd_ready_o, rd_data_o, commit_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] ci;
        pulse_reset();
        for (int n = 0; n < 800; n++) begin
            ci = 4'($urandom_range(15));
            if (mq.size() > 0 && $urandom_range(3) != 0)
                ci = 4'(mq[$urandom_range(mq.size() - 1)].tag);
            rst = ($urandom_range(199) == 0);
            drive($urandom_range(9) < 6, 5'($urandom_range(31)), $urandom_range(1) == 1, ci,
                  $urandom, $urandom_range(49) == 0, 4'($urandom_range(15)));
            model_expect();
            checks++;
            if (alloc_ready_o !== exp_ready || speculate_o !== exp_grant ||
                alloc_rob_idx_o !== 4'(m_tail) || count_o !== 5'(mq.size()) ||
                empty_o !== (mq.size() == 0) || commit_o !== exp_commit) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d: ready=%b spec=%b idx=%0d count=%0d empty=%b commit=%b required %b/%b/%0d/%0d/%b/%b",
                         n, alloc_ready_o, speculate_o, alloc_rob_idx_o, count_o, empty_o, commit_o,
                         exp_ready, exp_grant, m_tail, mq.size(), mq.size() == 0, exp_commit);
            end
            if (exp_grant) begin
                checks++;
                if (speculate_idx_o !== alloc_rd_i || speculate_data_o !== 4'(m_tail)) begin
                    errors++;
                    $display("[TB] FAIL rand_spec cyc %0d: rd=%0d tag=%0d required %0d/%0d",
                             n, speculate_idx_o, speculate_data_o, alloc_rd_i, m_tail);
                end
            end
            if (exp_commit) begin
                checks++;
                if (commit_idx_o !== exp_commit_rd || commit_data_o !== exp_commit_data ||
                    commit_rob_idx_o !== 4'(exp_head)) begin
                    errors++;
                    $display("[TB] FAIL rand_commit cyc %0d: rd=%0d data=%h rob=%0d required %0d/%h/%0d",
                             n, commit_idx_o, commit_data_o, commit_rob_idx_o,
                             exp_commit_rd, exp_commit_data, exp_head);
                end
            end
            checks++;
            if (rd_ready_o !== exp_lk_ready || (exp_lk_ready && rd_data_o !== exp_lk_data)) begin
                errors++;
                $display("[TB] FAIL rand_lookup cyc %0d: rdy=%b data=%h required %b/%h",
                         n, rd_ready_o, rd_data_o, exp_lk_ready, exp_lk_data);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_lookup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
